// File: rtl/proc_fetch_ctrl.sv
// proc_fetch_ctrl: instruction-fetch sequencer driving the PC register, the imem request and decode handoff.
// Optional: define PROC_FETCH_MISALIGN_TRAP_EN to send misaligned jump/branch targets to TRAP_VEC.
module proc_fetch_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TRAP_VEC   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic                  o_ld_pc,
  output logic [DATA_WIDTH-1:0] o_next_pc,
  input  logic                  i_br_taken,
  input  logic [DATA_WIDTH-1:0] i_br_target,
  input  logic                  i_jmp,
  input  logic [DATA_WIDTH-1:0] i_jmp_target,
  input  logic                  i_trap,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic                  o_instr_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0] o_instr_pc,
  input  logic                  i_stall,
  output logic                  o_misalign
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_VALID = 2'd3;

  localparam logic [DATA_WIDTH-1:0] TRAP_ADDR = DATA_WIDTH'(TRAP_VEC);

  logic [1:0]            state;
  logic                  redirect, take_redirect, misalign;
  logic [DATA_WIDTH-1:0] raw_target, target, pc_inc, fetch_addr;

  always_comb begin
    redirect = i_trap | i_jmp | i_br_taken;
    if (i_trap)     raw_target = TRAP_ADDR;
    else if (i_jmp) raw_target = i_jmp_target;
    else            raw_target = i_br_target;
`ifdef PROC_FETCH_MISALIGN_TRAP_EN
    misalign = !i_trap && (raw_target[1:0] != 2'b00);
    target   = misalign ? TRAP_ADDR : raw_target;
`else
    misalign = 1'b0;
    target   = raw_target & ~DATA_WIDTH'(3);
`endif
  end

  // Redirects are honoured in every state except IDLE; reset masks the PC strobe combinationally.
  assign pc_inc        = i_pc + DATA_WIDTH'(4);
  assign take_redirect = !rst && (state != S_IDLE) && redirect;
  assign o_ld_pc       = take_redirect || (!rst && (state == S_FETCH) && i_imem_ack);
  assign o_next_pc     = take_redirect ? target : pc_inc;
  assign o_misalign    = take_redirect & misalign;
  assign o_imem_req    = (state == S_FETCH) || (state == S_DRAIN);

  // The next fetch address is whatever the PC register will hold after this edge.
  assign fetch_addr    = o_ld_pc ? o_next_pc : i_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      o_imem_addr   <= '0;
      o_instr       <= '0;
      o_instr_pc    <= '0;
      o_instr_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state       <= S_FETCH;
          o_imem_addr <= fetch_addr;
        end
        S_FETCH: begin
          if (i_imem_ack) begin
            if (redirect) begin
              o_imem_addr <= fetch_addr;
            end else begin
              o_instr       <= i_imem_rdata;
              o_instr_pc    <= o_imem_addr;
              o_instr_valid <= 1'b1;
              state         <= S_VALID;
            end
          end else if (redirect) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_imem_ack) begin
            state       <= S_FETCH;
            o_imem_addr <= fetch_addr;
          end
        end
        S_VALID: begin
          if (redirect || !i_stall) begin
            o_instr_valid <= 1'b0;
            state         <= S_FETCH;
            o_imem_addr   <= fetch_addr;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_fetch_ctrl.sv
// Bench for proc_fetch_ctrl: directed scenarios then random traffic against a request-level reference model.
module tb_proc_fetch_ctrl;
  localparam int W = 32;
  localparam logic [W-1:0] TRAP    = 32'h10;
  localparam logic [W-1:0] PC_INIT = 32'h80;

  logic         clk = 1'b0, rst = 1'b0;
  logic [W-1:0] pc;
  logic         ld_pc, br_taken, jmp, trap, imem_req, imem_ack, instr_valid, stall, misalign;
  logic [W-1:0] next_pc, br_target, jmp_target, imem_addr, imem_rdata, instr, instr_pc;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // reference model: one outstanding request (possibly stale) or one held instruction
  bit           m_run, m_busy, m_stale, m_have;
  logic [W-1:0] m_pc, m_addr, m_instr, m_ipc;
  logic [W-1:0] ipc_log[$];
  logic [W-1:0] saved;

  proc_fetch_ctrl #(.DATA_WIDTH(W), .TRAP_VEC(16)) dut (
    .clk(clk), .rst(rst), .i_pc(pc), .o_ld_pc(ld_pc), .o_next_pc(next_pc),
    .i_br_taken(br_taken), .i_br_target(br_target), .i_jmp(jmp), .i_jmp_target(jmp_target),
    .i_trap(trap), .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack),
    .i_imem_rdata(imem_rdata), .o_instr_valid(instr_valid), .o_instr(instr),
    .o_instr_pc(instr_pc), .i_stall(stall), .o_misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_target(output bit mis);
    logic [W-1:0] t;
    mis = 1'b0;
    if (trap) return TRAP;
    t = jmp ? jmp_target : br_target;
`ifdef PROC_FETCH_MISALIGN_TRAP_EN
    if (t % 4 != 0) begin
      mis = 1'b1;
      return TRAP;
    end
    return t;
`else
    return t - (t % 4);
`endif
  endfunction

  task automatic drive(input bit a_br, input bit a_jmp, input bit a_trap, input bit a_ack,
                       input bit a_stall, input logic [W-1:0] a_bt, input logic [W-1:0] a_jt);
    br_taken = a_br; jmp = a_jmp; trap = a_trap; imem_ack = a_ack; stall = a_stall;
    br_target = a_bt; jmp_target = a_jt; imem_rdata = $urandom;
  endtask

  // One clock: drive, check against the model mid-cycle, clock, then advance PC register and model.
  task automatic step(input bit a_br, input bit a_jmp, input bit a_trap, input bit a_ack,
                      input bit a_stall, input logic [W-1:0] a_bt, input logic [W-1:0] a_jt);
    bit           redir, mis, exp_ld, cap_ld;
    logic [W-1:0] tgt, exp_next, new_pc, cap_next, rd;
    drive(a_br, a_jmp, a_trap, a_ack, a_stall, a_bt, a_jt);
    rd = imem_rdata;
    #1;
    redir    = m_run && (a_br || a_jmp || a_trap);
    tgt      = ref_target(mis);
    exp_ld   = redir || (m_busy && a_ack && !m_stale);
    exp_next = redir ? tgt : m_pc + 4;
    chk("ld_pc", W'(ld_pc), W'(exp_ld));
    if (exp_ld) chk("next_pc", next_pc, exp_next);
    chk("imem_req", W'(imem_req), W'(m_busy));
    chk("imem_addr", imem_addr, m_addr);
    chk("instr_valid", W'(instr_valid), W'(m_have));
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("misalign", W'(misalign), W'(redir && mis));
    if (instr_valid) ipc_log.push_back(instr_pc);
    cap_ld = ld_pc; cap_next = next_pc;
    @(posedge clk); #1;
    if (cap_ld) pc = cap_next;
    new_pc = exp_ld ? exp_next : m_pc;
    if (!m_run) begin
      m_run = 1; m_busy = 1; m_stale = 0; m_addr = m_pc;
    end else if (m_busy) begin
      if (a_ack) begin
        if (m_stale || redir) begin
          m_addr = new_pc; m_stale = 0;
        end else begin
          m_busy = 0; m_have = 1; m_instr = rd; m_ipc = m_addr;
        end
      end else if (redir) m_stale = 1;
    end else if (redir || !a_stall) begin
      m_have = 0; m_busy = 1; m_stale = 0; m_addr = new_pc;
    end
    m_pc = new_pc;
  endtask

  // Reset with a trap and a late ack pending: nothing may leak out while rst is high.
  task automatic do_reset(input int n);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
    rst = 1'b1;
    #1;
    chk("rst_async_req", W'(imem_req), '0);
    chk("rst_ld_pc", W'(ld_pc), '0);
    pc = PC_INIT;
    m_run = 0; m_busy = 0; m_stale = 0; m_have = 0;
    m_pc = PC_INIT; m_addr = '0; m_instr = '0; m_ipc = '0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_addr", imem_addr, '0);
    chk("rst_valid", W'(instr_valid), '0);
    chk("rst_instr", instr, '0);
    chk("rst_instr_pc", instr_pc, '0);
    chk("rst_misalign", W'(misalign), '0);
    rst = 1'b0;
  endtask

  initial begin
    pc = PC_INIT;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;

    // back-to-back fetches with same-cycle ack; late ack in the IDLE cycle must be ignored
    do_reset(2);
    ipc_log.delete();
    repeat (7) step(0, 0, 0, 1, 0, '0, '0);
    chk("seq_len", W'(ipc_log.size()), W'(3));
    chk("seq0", ipc_log[0], 32'h80);
    chk("seq1", ipc_log[1], 32'h84);
    chk("seq2", ipc_log[2], 32'h88);

    // 3-cycle ack latency at 0x80
    do_reset(1);
    step(0, 0, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, 0, '0, '0);
    chk("lat_addr", imem_addr, 32'h80);
    chk("lat_req", W'(imem_req), W'(1));
    step(0, 0, 0, 1, 0, '0, '0);
    chk("lat_valid", W'(instr_valid), W'(1));

    // branch while the 0x84 request is outstanding
    step(0, 0, 0, 0, 0, '0, '0);
    step(1, 0, 0, 0, 0, 32'h200, '0);
    step(0, 0, 0, 1, 0, '0, '0);
    chk("br_addr", imem_addr, 32'h200);
    step(0, 0, 0, 1, 0, '0, '0);
    chk("br_ipc", instr_pc, 32'h200);
    chk("br_pc", pc, 32'h204);

    // trap beats jump beats branch
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h300);
    #1;
    chk("prio_ld", W'(ld_pc), W'(1));
    chk("prio_next", next_pc, TRAP);
    step(1, 1, 1, 0, 0, 32'h400, 32'h300);
    step(0, 0, 0, 1, 0, '0, '0);

    // stall held 4 cycles in VALID, ack noise ignored
    saved = instr;
    repeat (4) step(0, 0, 0, 1, 1, '0, '0);
    chk("stall_instr", instr, saved);
    chk("stall_req", W'(imem_req), '0);
    step(0, 0, 0, 0, 0, '0, '0);
    chk("stall_next_req", W'(imem_req), W'(1));
    chk("stall_next_addr", imem_addr, 32'h14);
    step(0, 0, 0, 1, 0, '0, '0);

    // misaligned jump
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h102);
    #1;
`ifdef PROC_FETCH_MISALIGN_TRAP_EN
    chk("mis_next", next_pc, TRAP);
    chk("mis_pulse", W'(misalign), W'(1));
`else
    chk("mis_next", next_pc, 32'h100);
    chk("mis_pulse", W'(misalign), '0);
`endif
    step(0, 1, 0, 0, 0, '0, 32'h102);
    step(0, 0, 0, 1, 0, '0, '0);

    // PC increment wraps to zero
    step(0, 1, 0, 0, 0, '0, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    #1;
    chk("wrap_next", next_pc, '0);
    step(0, 0, 0, 1, 0, '0, '0);
    chk("wrap_pc", pc, '0);

    // random traffic with one mid-run reset
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] bt, jt;
      if (i == 200) do_reset(1);
      bt = $urandom; jt = $urandom;
      if ($urandom_range(0, 1) == 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) jt[1:0] = 2'b00;
      step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0, bt, jt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
